// File: rtl/vga_sync_rx.sv
// -----------------------------------------------------------------------------
// vga_sync_rx
//   Receive-side companion of the VGA timing generator. Samples an incoming
//   active-low h_sync/v_sync pair on the pixel clock and recovers the pixel
//   and line position. It measures the line length and the frame height, and
//   declares lock once LOCK_FRAMES consecutive frames match. While locked it
//   regenerates vid_on so downstream capture or overlay logic can use it.
//
// Ports
//   clk_65M     in   1   pixel clock, the only clock
//   clear       in   1   synchronous active-high reset
//   h_sync_in   in   1   horizontal sync, active low
//   v_sync_in   in   1   vertical sync, active low
//   h_count     out  17  recovered pixel index in line (lags transmitter by 2)
//   v_count     out  17  recovered line index in frame
//   vid_on      out  1   active-video window, gated by locked
//   locked      out  1   timing stable
//   frame_start out  1   one-cycle pulse per detected v_sync fall
//   line_len    out  17  clocks between the last two h_sync falls
//   frame_lines out  17  lines in the last complete frame
//   sync_err    out  1   one-cycle pulse on loss of lock or counter timeout
// -----------------------------------------------------------------------------
module vga_sync_rx #(
    parameter int HBP         = 296,
    parameter int HFP         = 1320,
    parameter int VBP         = 35,
    parameter int VFP         = 803,
    parameter int LOCK_FRAMES = 2,
    parameter int MAX_LINE    = 4095,
    parameter int MAX_FRAME   = 2047
) (
    input  logic        clk_65M,
    input  logic        clear,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    output logic [16:0] h_count,
    output logic [16:0] v_count,
    output logic        vid_on,
    output logic        locked,
    output logic        frame_start,
    output logic [16:0] line_len,
    output logic [16:0] frame_lines,
    output logic        sync_err
);

    localparam logic [16:0] HBP_C       = 17'(HBP);
    localparam logic [16:0] HFP_C       = 17'(HFP);
    localparam logic [16:0] VBP_C       = 17'(VBP);
    localparam logic [16:0] VFP_C       = 17'(VFP);
    localparam logic [16:0] MAX_LINE_C  = 17'(MAX_LINE);
    localparam logic [16:0] MAX_FRAME_C = 17'(MAX_FRAME);
    localparam int          MW          = $clog2(LOCK_FRAMES + 1) + 1;
    localparam logic [MW-1:0] LOCK_C    = MW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t        state;
    logic          h_sync_p1, h_sync_p2;
    logic          v_sync_p1, v_sync_p2;
    logic          v_pend;
    logic          frame_bad;
    logic [MW-1:0] match_cnt;

    logic          h_fall, v_fall;
    logic [16:0]   h_inc, v_inc;
    logic [16:0]   h_next, v_next;
    logic          v_restart, v_pend_next;
    logic          h_timeout, v_timeout;
    logic          line_bad, lines_bad;
    logic [MW-1:0] match_inc;

    // Saturating increment: holds at max instead of wrapping.
    function automatic logic [16:0] sat_inc(input logic [16:0] val,
                                            input logic [16:0] max);
        return (val >= max) ? max : val + 17'd1;
    endfunction

    // Sync edge detect on the second sample stage
    assign h_fall = h_sync_p2 & ~h_sync_p1;
    assign v_fall = v_sync_p2 & ~v_sync_p1;

    assign h_inc     = h_count + 17'd1;
    assign v_inc     = v_count + 17'd1;
    assign match_inc = match_cnt + MW'(1);

    // A v fall only restarts the line count at a line boundary, so that the
    // first line of the frame starts with h_count = 0.
    assign v_restart   = h_fall & (v_pend | v_fall);
    assign v_pend_next = v_restart ? 1'b0 : (v_pend | v_fall);

    assign h_next = h_fall ? 17'd0 : sat_inc(h_count, MAX_LINE_C);
    assign v_next = v_restart ? 17'd0 :
                    h_fall    ? sat_inc(v_count, MAX_FRAME_C) : v_count;

    // Timeouts fire only on the step into saturation, so they pulse once.
    assign h_timeout = (h_next == MAX_LINE_C)  && (h_count != MAX_LINE_C);
    assign v_timeout = (v_next == MAX_FRAME_C) && (v_count != MAX_FRAME_C);

    assign line_bad  = h_fall && (h_inc != line_len);
    assign lines_bad = v_fall && (v_inc != frame_lines);

    assign vid_on = locked &&
                    (h_count > HBP_C) && (h_count < HFP_C) &&
                    (v_count > VBP_C) && (v_count < VFP_C);

    always_ff @(posedge clk_65M) begin
        if (clear) begin
            h_sync_p1   <= 1'b1;
            h_sync_p2   <= 1'b1;
            v_sync_p1   <= 1'b1;
            v_sync_p2   <= 1'b1;
            h_count     <= 17'd0;
            v_count     <= 17'd0;
            v_pend      <= 1'b0;
            line_len    <= 17'd0;
            frame_lines <= 17'd0;
            match_cnt   <= '0;
            frame_bad   <= 1'b0;
            state       <= SEARCH;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            // Stage p1/p2: two-register sampling of the sync inputs
            h_sync_p1 <= h_sync_in;
            h_sync_p2 <= h_sync_p1;
            v_sync_p1 <= v_sync_in;
            v_sync_p2 <= v_sync_p1;

            h_count <= h_next;
            v_count <= v_next;
            v_pend  <= v_pend_next;
            if (h_fall) line_len    <= h_inc;
            if (v_fall) frame_lines <= v_inc;
            frame_start <= v_fall;
            sync_err    <= 1'b0;

            if (h_timeout || v_timeout) begin
                sync_err  <= 1'b1;
                locked    <= 1'b0;
                match_cnt <= '0;
                frame_bad <= 1'b0;
                state     <= SEARCH;
            end else begin
                case (state)
                    SEARCH: begin
                        if (v_fall) begin
                            match_cnt <= '0;
                            frame_bad <= 1'b0;
                            state     <= ACQUIRE;
                        end
                    end
                    ACQUIRE: begin
                        if (v_fall) begin
                            // A bad line ending on this very fall still
                            // belongs to the frame being judged.
                            frame_bad <= 1'b0;
                            if (!frame_bad && !line_bad && !lines_bad) begin
                                if (match_inc >= LOCK_C) begin
                                    match_cnt <= '0;
                                    locked    <= 1'b1;
                                    state     <= LOCKED;
                                end else begin
                                    match_cnt <= match_inc;
                                end
                            end else begin
                                match_cnt <= '0;
                            end
                        end else if (line_bad) begin
                            frame_bad <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (line_bad || lines_bad) begin
                            sync_err  <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                            frame_bad <= 1'b0;
                            state     <= ACQUIRE;
                        end
                    end
                    default: begin
                        locked <= 1'b0;
                        state  <= SEARCH;
                    end
                endcase
            end
        end
    end

endmodule
